// File: rtl/demux_1x2_skid.sv
// -----------------------------------------------------------------------------
// demux_1x2_skid
// 1-to-2 in-order routing stage with a small FIFO between input and outputs.
// Each accepted result is stored as {sel, data}. The entry at the head of the
// FIFO is offered to the channel chosen by its sel bit. A head that is stalled
// blocks every entry behind it (head-of-line blocking keeps strict order).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous discard of all buffered entries
//   in_valid/ready  upstream handshake; in_ready depends on occupancy only
//   in_data/in_sel  result byte and destination select (0 -> out0, 1 -> out1)
//   outK_valid/ready/data  downstream channels; data is 0 when not valid
//   cnt0/cnt1       per-channel transfer counters (wrap, not cleared by flush)
//   count           current FIFO occupancy
// -----------------------------------------------------------------------------
module demux_1x2_skid #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sel,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [DATA_W-1:0]        out0_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [DATA_W-1:0]        out1_data,
    output logic [CNT_W-1:0]         cnt0,
    output logic [CNT_W-1:0]         cnt1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_C = OCC_W'(DEPTH);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_sel;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_empty;
    logic              w_full;
    logic              w_head_sel;
    logic [DATA_W-1:0] w_head_data;
    logic              w_push;
    logic              w_pop0;
    logic              w_pop1;
    logic              w_pop;

    // Handshake and head decode; everything here derives from registered state
    // plus the handshake inputs, so there is no input-to-output data bypass.
    always_comb begin
        w_empty     = (r_count == '0);
        w_full      = (r_count == FULL_C);
        w_head_sel  = r_sel[r_rd_ptr];
        w_head_data = r_data[r_rd_ptr];
        in_ready    = ~w_full;
        out0_valid  = 1'b0;
        out1_valid  = 1'b0;
        out0_data   = '0;
        out1_data   = '0;
        if (!w_empty) begin
            if (w_head_sel) begin
                out1_valid = 1'b1;
                out1_data  = w_head_data;
            end else begin
                out0_valid = 1'b1;
                out0_data  = w_head_data;
            end
        end else begin
            // Empty FIFO: keep stale storage and in_sel/in_data off the outputs.
            out0_valid = 1'b0;
            out1_valid = 1'b0;
        end
        w_push = in_valid & ~w_full;
        w_pop0 = out0_valid & out0_ready;
        w_pop1 = out1_valid & out1_ready;
        w_pop  = w_pop0 | w_pop1;
    end

    // Pointer and occupancy tracking; flush wins over any push/pop that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: {sel, data} written at the write pointer on a push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_sel[r_wr_ptr]  <= in_sel;
            r_data[r_wr_ptr] <= in_data;
        end
    end

    // Per-channel transfer counters; a pop cancelled by flush is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (!flush) begin
            if (w_pop0) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_pop1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign cnt0  = r_cnt0;
    assign cnt1  = r_cnt1;
    assign count = r_count;

endmodule
